// File: rtl/maxpool_pkg.sv
// Shared types and default widths for the max-pool sequencer.
package maxpool_pkg;

    localparam int DATA_W_DEF = 21;
    localparam int ADDR_W_DEF = 12;
    localparam int DIM_W_DEF  = 8;
    localparam int MAX_K      = 15;
    localparam int K_W        = $clog2(MAX_K + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        DRAIN,
        WRITE,
        FIN
    } state_t;

endpackage

// File: rtl/maxpool_win_acc.sv
// Signed running-max accumulator for one pooling window; 'first' reloads it.
module maxpool_win_acc #(
    parameter int DATA_W = 21
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     first,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] acc
);

    // Strict greater-than: ties keep the earlier sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (valid && (first || (din > acc))) begin
            acc <= din;
        end
    end

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// Non-overlapping KxK max-pool sequencer over a 1-cycle-latency source RAM.
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | validate latched config, init pointers
// READ  | one source read per cycle, K*K reads
// DRAIN | last read data lands in accumulator
// WRITE | hold result until wr_ready
// FIN   | done pulse, back to IDLE
module maxpool_seq_ctrl
    import maxpool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIM_W-1:0]         cfg_width,
    input  logic [DIM_W-1:0]         cfg_height,
    input  logic [3:0]               cfg_k,
    input  logic [ADDR_W-1:0]        cfg_src_base,
    input  logic [ADDR_W-1:0]        cfg_dst_base,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cfg,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    input  logic                     wr_ready
);

    state_t state, state_nx;

    logic [K_W-1:0]    k_q, kx, ky;
    logic [DIM_W-1:0]  w_q, h_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [ADDR_W-1:0] line_ptr, win_base, row_next, line_nx, col_nx;
    logic [DIM_W:0]    col_pos, row_pos, k_ext, k2;
    logic              cfg_bad, kx_last, ky_last, col_last, row_last;
    logic              rd_vld_q, rd_first_q;
    logic signed [DATA_W-1:0] acc;

    assign k_ext    = (DIM_W+1)'(k_q);
    assign k2       = {k_ext[DIM_W-1:0], 1'b0};
    assign cfg_bad  = (k_q == '0) || (k_ext > {1'b0, w_q}) || (k_ext > {1'b0, h_q});
    assign kx_last  = (kx == k_q - K_W'(1));
    assign ky_last  = (ky == k_q - K_W'(1));
    // Another window fits only if its right/bottom edge stays inside the map.
    assign col_last = (col_pos + k2) > {1'b0, w_q};
    assign row_last = (row_pos + k2) > {1'b0, h_q};
    assign line_nx  = line_ptr + ADDR_W'(w_q);
    assign col_nx   = win_base + ADDR_W'(k_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        err_cfg  = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = CHECK;
            CHECK: begin
                busy = 1'b1;
                if (cfg_bad) begin
                    done     = 1'b1;
                    err_cfg  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (kx_last && ky_last) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) state_nx = (col_last && row_last) ? FIN : READ;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0; w_q <= '0; h_q <= '0; src_q <= '0; dst_q <= '0;
            kx <= '0; ky <= '0; col_pos <= '0; row_pos <= '0;
            line_ptr <= '0; win_base <= '0; row_next <= '0;
            rd_addr <= '0; wr_addr <= '0;
            rd_vld_q <= 1'b0; rd_first_q <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_first_q <= rd_en && (kx == '0) && (ky == '0);
            case (state)
                IDLE: if (start) begin
                    k_q <= cfg_k; w_q <= cfg_width; h_q <= cfg_height;
                    src_q <= cfg_src_base; dst_q <= cfg_dst_base;
                end
                CHECK: begin
                    kx <= '0; ky <= '0; col_pos <= '0; row_pos <= '0;
                    line_ptr <= src_q; win_base <= src_q; row_next <= src_q;
                    rd_addr <= src_q; wr_addr <= dst_q;
                end
                READ: begin
                    if (kx_last) begin
                        kx <= '0;
                        if (ky_last) begin
                            ky <= '0;
                            // The left-most window's bottom line + W is the next output row start.
                            if (col_pos == '0) row_next <= line_nx;
                        end else begin
                            ky       <= ky + K_W'(1);
                            line_ptr <= line_nx;
                            rd_addr  <= line_nx;
                        end
                    end else begin
                        kx      <= kx + K_W'(1);
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                WRITE: if (wr_ready) begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                    if (col_last) begin
                        col_pos  <= '0;
                        row_pos  <= row_pos + k_ext;
                        win_base <= row_next;
                        line_ptr <= row_next;
                        rd_addr  <= row_next;
                    end else begin
                        col_pos  <= col_pos + k_ext;
                        win_base <= col_nx;
                        line_ptr <= col_nx;
                        rd_addr  <= col_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    maxpool_win_acc #(.DATA_W(DATA_W)) u_win_acc (
        .clk   (clk),
        .reset (reset),
        .first (rd_first_q),
        .valid (rd_vld_q),
        .din   (rd_data),
        .acc   (acc)
    );

`ifdef MAXPOOL_RELU_EN
    assign wr_data = acc[DATA_W-1] ? '0 : acc;
`else
    assign wr_data = acc;
`endif

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Directed bench for maxpool_seq_ctrl: RAM model, write/read monitor, hand-computed results.
module tb_maxpool_seq_ctrl;

    localparam int DATA_W = 21;
    localparam int ADDR_W = 12;
    localparam int DIM_W  = 8;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, wr_ready = 1'b1;
    logic [DIM_W-1:0] cfg_width = '0, cfg_height = '0;
    logic [3:0] cfg_k = '0;
    logic [ADDR_W-1:0] cfg_src_base = '0, cfg_dst_base = '0;
    logic busy, done, err_cfg, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic signed [DATA_W-1:0] rd_data = '0, wr_data;

    maxpool_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_k(cfg_k),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .busy(busy), .done(done), .err_cfg(err_cfg),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    logic signed [DATA_W-1:0] mem [0:4095];
    bit     rd_seen [0:4095];
    int     cyc = 0, rd_cnt = 0, wr_n = 0, done_cnt = 0, err_cnt = 0, err_alone = 0;
    int     last_wr_cyc = 0, done_cyc = 0;
    longint wq_addr [16];
    longint wq_data [16];
    int     checks = 0, errors = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        // Garbage when not reading exposes a capture on the wrong cycle.
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= DATA_W'($urandom);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                rd_cnt = rd_cnt + 1;
                rd_seen[rd_addr] = 1'b1;
            end
            if (wr_en && wr_ready) begin
                if (wr_n < 16) begin
                    wq_addr[wr_n] = longint'(wr_addr);
                    wq_data[wr_n] = longint'(wr_data);
                end
                wr_n = wr_n + 1;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                if (err_cfg) err_cnt = err_cnt + 1;
            end
            if (err_cfg && !done) err_alone = err_alone + 1;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint relu(input longint v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        rd_cnt = 0; wr_n = 0; done_cnt = 0; err_cnt = 0; err_alone = 0;
        for (int i = 0; i < 4096; i++) rd_seen[i] = 1'b0;
    endtask

    task automatic set_cfg(input int w, input int h, input int k, input int src, input int dst);
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_k = 4'(k);
        cfg_src_base = ADDR_W'(src); cfg_dst_base = ADDR_W'(dst);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, longint'(done), 1);
    endtask

    // Start a job and wait for done; optionally fire a start in the done cycle.
    task automatic run_job(input string tag, input int w, input int h, input int k,
                           input int src, input int dst, input bit start_in_fin);
        clear_rec();
        set_cfg(w, h, k, src, dst);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, longint'(busy), 1);
        wait_done(tag);
        if (start_in_fin) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check({tag, "_fin_start_ignored"}, longint'(busy), 0);
            tick();
            check({tag, "_fin_start_idle"}, longint'(busy), 0);
        end else begin
            tick();
        end
    endtask

    task automatic check_writes(input string tag, input int n, input int base, input longint e [4]);
        check({tag, "_wr_count"}, wr_n, n);
        for (int i = 0; i < n && i < 4; i++) begin
            check({tag, "_wr_addr"}, wq_addr[i], base + i);
            check({tag, "_wr_data"}, wq_data[i], relu(e[i]));
        end
    endtask

    initial begin
        longint a, d;
        int n, saved;

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        reset = 1'b0;
        tick();

        // 4x4 ramp, K=2
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);
        run_job("ramp", 4, 4, 2, 0, 0, 1'b1);
        check_writes("ramp", 4, 0, '{5, 7, 13, 15});
        check("ramp_done_lat", done_cyc - last_wr_cyc, 1);
        check("ramp_reads", rd_cnt, 16);
        check("ramp_done_cnt", done_cnt, 1);

        // All-negative data: first sample must load, no zero init
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(-5 - i);
        run_job("neg", 4, 4, 2, 0, 0, 1'b0);
        check_writes("neg", 4, 0, '{-5, -7, -13, -15});

        // Mixed sign, non-square 4x2: signed compare
        mem[300] = DATA_W'(-1);       mem[301] = DATA_W'(3);
        mem[302] = DATA_W'(-8);       mem[303] = DATA_W'(-2);
        mem[304] = DATA_W'(-1048576); mem[305] = DATA_W'(2);
        mem[306] = DATA_W'(-9);       mem[307] = DATA_W'(-2);
        run_job("mix", 4, 2, 2, 300, 40, 1'b0);
        check_writes("mix", 2, 40, '{3, -2, 0, 0});

        // K=1 copy
        mem[200] = DATA_W'(-3); mem[201] = DATA_W'(7);
        mem[202] = DATA_W'(-100000); mem[203] = DATA_W'(1048575);
        run_job("copy", 2, 2, 1, 200, 50, 1'b0);
        check_writes("copy", 4, 50, '{-3, 7, -100000, 1048575});
        check("copy_reads", rd_cnt, 4);

        // 5x5, K=2: leftover row/column untouched
        for (int i = 0; i < 25; i++) mem[i] = DATA_W'(i);
        run_job("odd", 5, 5, 2, 0, 100, 1'b0);
        check_writes("odd", 4, 100, '{6, 8, 16, 18});
        check("odd_reads", rd_cnt, 16);
        for (int i = 0; i < 25; i++)
            if (i % 5 == 4 || i >= 20) check("odd_unread", longint'(rd_seen[i]), 0);

        // Config errors
        run_job("k0", 4, 4, 0, 0, 0, 1'b0);
        check("k0_err", err_cnt, 1);
        check("k0_done", done_cnt, 1);
        check("k0_err_alone", err_alone, 0);
        check("k0_reads", rd_cnt, 0);
        check("k0_writes", wr_n, 0);
        run_job("k6", 5, 8, 6, 0, 0, 1'b0);
        check("k6_err", err_cnt, 1);
        check("k6_err_alone", err_alone, 0);
        check("k6_reads", rd_cnt, 0);
        check("k6_writes", wr_n, 0);

        // Back-pressure on second write
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);
        clear_rec();
        set_cfg(4, 4, 2, 0, 0);
        wr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!wr_en && n < 100) begin tick(); n++; end
        check("stall_first_wr_seen", wr_en, 1);
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        n = 0;
        while (!wr_en && n < 100) begin tick(); n++; end
        check("stall_second_wr_seen", wr_en, 1);
        a = longint'(wr_addr);
        d = longint'(wr_data);
        check("stall_addr", a, 1);
        check("stall_data", d, 7);
        repeat (2) begin
            tick();
            check("stall_wr_en_held", wr_en, 1);
            check("stall_addr_held", wr_addr, a);
            check("stall_data_held", wr_data, d);
            check("stall_no_rd", rd_en, 0);
        end
        wr_ready = 1'b1;
        wait_done("stall");
        tick();
        check_writes("stall", 4, 0, '{5, 7, 13, 15});

        // Reset during READ of window 2
        clear_rec();
        set_cfg(4, 4, 2, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (wr_n < 1 && n < 100) begin tick(); n++; end
        n = 0;
        while (!rd_en && n < 100) begin tick(); n++; end
        check("abort_in_read", rd_en, 1);
        reset = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_wr_data", wr_data, 0);
        reset = 1'b0;
        saved = rd_cnt;
        done_cnt = 0;
        repeat (5) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_reads", rd_cnt, saved);
        run_job("rerun", 4, 4, 2, 0, 0, 1'b0);
        check_writes("rerun", 4, 0, '{5, 7, 13, 15});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
